// File: rtl/branch_resolver.sv
// branch_resolver: D-stage branch compare, 2-bit BHT prediction,
// mispredict detection and branch/miss statistics.
module branch_resolver #(
  parameter int IDX_BITS = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       CMP_Op,
  input  logic             Valid_D,
  input  logic [31:0]      RS_D,
  input  logic [31:0]      RT_D,
  input  logic [31:0]      PC_D,
  input  logic [31:0]      PC_F,
  input  logic             Stall,
  output logic             Pred_F,
  output logic             Taken_D,
  output logic             Mispredict_D,
  output logic [CNT_W-1:0] Br_Count,
  output logic [CNT_W-1:0] Miss_Count
);

  localparam int N = 1 << IDX_BITS;

  logic [N-1:0][1:0]  bht_q, bht_d;
  logic               pred_d_q, pred_d_d;
  logic [CNT_W-1:0]   br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

  logic [IDX_BITS-1:0] f_idx;
  logic [IDX_BITS-1:0] d_idx;
  logic signed [31:0]  rs_s;
  logic signed [31:0]  rt_s;
  logic                branch_d;
  logic                upd;
  logic [1:0]          d_ent;
  logic                unused_pc;

  assign f_idx = PC_F[IDX_BITS+1:2];
  assign d_idx = PC_D[IDX_BITS+1:2];
  assign rs_s  = RS_D;
  assign rt_s  = RT_D;

  assign unused_pc = ^{PC_F[31:IDX_BITS+2], PC_F[1:0],
                       PC_D[31:IDX_BITS+2], PC_D[1:0]};

  // Resolve the branch condition from the decoded compare op.
  always_comb begin
    Taken_D = 1'b0;
    unique case (1'b1)
      (CMP_Op == 3'b000): Taken_D = (rs_s == rt_s);
      (CMP_Op == 3'b011): Taken_D = (rs_s != rt_s);
      (CMP_Op == 3'b001): Taken_D = (rs_s > 0);
      (CMP_Op == 3'b010): Taken_D = (rs_s <= 0);
      (CMP_Op == 3'b100): Taken_D = (rs_s >= 0);
      (CMP_Op == 3'b101): Taken_D = (rs_s < 0);
      default:            Taken_D = 1'b0;
    endcase
  end

  assign branch_d     = Valid_D & ~(CMP_Op[2] & CMP_Op[1]);
  assign upd          = branch_d & ~Stall;
  assign Pred_F       = bht_q[f_idx][1];
  assign Mispredict_D = upd & (Taken_D != pred_d_q);
  assign d_ent        = bht_q[d_idx];

  // Next-state for table, carried prediction and saturating counters.
  always_comb begin
    bht_d      = bht_q;
    pred_d_d   = pred_d_q;
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (upd) begin
      if (Taken_D && d_ent != 2'b11) begin
        bht_d[d_idx] = d_ent + 2'b01;
      end else if (!Taken_D && d_ent != 2'b00) begin
        bht_d[d_idx] = d_ent - 2'b01;
      end
      if (~&br_cnt_q) begin
        br_cnt_d = br_cnt_q + CNT_W'(1);
      end
    end
    if (Mispredict_D && ~&miss_cnt_q) begin
      miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end
    if (!Stall) begin
      pred_d_d = Mispredict_D ? 1'b0 : Pred_F;
    end
  end

  // State registers, cleared asynchronously to weak-not-taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bht_q      <= {N{2'b01}};
      pred_d_q   <= 1'b0;
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      bht_q      <= bht_d;
      pred_d_q   <= pred_d_d;
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign Br_Count   = br_cnt_q;
  assign Miss_Count = miss_cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed stimulus, reference model and
// per-cycle comparison for branch_resolver.
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  op;
  logic        valid;
  logic [31:0] rs, rt, pcd, pcf;
  logic        stall;
  logic        pred_f, taken, mis;
  logic [15:0] br_cnt, miss_cnt;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  logic [1:0] m_bht [16];
  logic       m_pred;
  int         m_br, m_miss;
  logic       mb, mt, mm, mpf;

  branch_resolver #(.IDX_BITS(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .CMP_Op(op), .Valid_D(valid),
    .RS_D(rs), .RT_D(rt), .PC_D(pcd), .PC_F(pcf), .Stall(stall),
    .Pred_F(pred_f), .Taken_D(taken), .Mispredict_D(mis),
    .Br_Count(br_cnt), .Miss_Count(miss_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic f_taken(logic [2:0] o, logic [31:0] a,
                                   logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (o)
      3'd0: return sa == sb;
      3'd3: return sa != sb;
      3'd1: return sa > 0;
      3'd2: return sa <= 0;
      3'd4: return sa >= 0;
      3'd5: return sa < 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic f_branch(logic v, logic [2:0] o);
    return v && (o != 3'd6) && (o != 3'd7);
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // Reference model: table, carried prediction, saturating stats.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      foreach (m_bht[i]) m_bht[i] = 2'd1;
      m_pred = 1'b0;
      m_br   = 0;
      m_miss = 0;
    end else if (!stall) begin
      mb  = f_branch(valid, op);
      mt  = f_taken(op, rs, rt);
      mm  = mb && (mt != m_pred);
      mpf = m_bht[pcf[5:2]][1];
      if (mb) begin
        if (mt && m_bht[pcd[5:2]] < 2'd3) m_bht[pcd[5:2]]++;
        else if (!mt && m_bht[pcd[5:2]] > 2'd0) m_bht[pcd[5:2]]--;
        if (m_br < 65535) m_br++;
      end
      if (mm && m_miss < 65535) m_miss++;
      m_pred = mm ? 1'b0 : mpf;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_pred_f", 32'(pred_f), 32'(m_bht[pcf[5:2]][1]));
      chk("cmp_taken", 32'(taken), 32'(f_taken(op, rs, rt)));
      chk("cmp_mis", 32'(mis), 32'(f_branch(valid, op) && !stall &&
                                   (f_taken(op, rs, rt) != m_pred)));
      chk("cmp_br", 32'(br_cnt), 32'(m_br));
      chk("cmp_miss", 32'(miss_cnt), 32'(m_miss));
    end
  end

  task automatic drive(logic v, logic [2:0] o, logic [31:0] a,
                       logic [31:0] b, logic [31:0] d, logic [31:0] f,
                       logic s);
    @(posedge clk);
    #1;
    valid = v; op = o; rs = a; rt = b; pcd = d; pcf = f; stall = s;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    valid = 1'b0; op = 3'd7; rs = '0; rt = '0;
    pcd = '0; pcf = '0; stall = 1'b0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // first taken branch mispredicts against weak-NT
    drive(1, 3'd0, 5, 5, 32'h100, 32'h104, 0);
    at_neg();
    chk("r34_taken", 32'(taken), 1);
    chk("r34_mis", 32'(mis), 1);
    chk("r34_br_pre", 32'(br_cnt), 0);
    drive(0, 3'd7, 0, 0, 32'h100, 32'h100, 0);
    at_neg();
    chk("r34_br", 32'(br_cnt), 1);
    chk("r34_miss", 32'(miss_cnt), 1);
    chk("r34_entry_t", 32'(pred_f), 1);

    // repeated taken saturates and predicts correctly
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'd0, 7, 7, 32'h100, 32'h100, 0);
      at_neg();
      chk("r35_mis", 32'(mis), 0);
    end
    drive(0, 3'd7, 0, 0, 32'h100, 32'h100, 0);
    at_neg();
    chk("r35_pred_f", 32'(pred_f), 1);
    chk("r35_br", 32'(br_cnt), 4);
    chk("r35_miss", 32'(miss_cnt), 1);

    // signed compares
    drive(1, 3'd1, 32'h8000_0000, 0, 32'h10C, 32'h104, 0);
    at_neg();
    chk("r36_bgtz", 32'(taken), 0);
    drive(1, 3'd5, 32'h8000_0000, 0, 32'h10C, 32'h104, 0);
    at_neg();
    chk("r36_bltz", 32'(taken), 1);

    // stalled branch updates once
    for (int i = 0; i < 4; i++) begin
      drive(1, 3'd3, 1, 2, 32'h108, 32'h100, 1);
      at_neg();
      chk("r37_stall_mis", 32'(mis), 0);
      chk("r37_stall_br", 32'(br_cnt), 6);
    end
    drive(1, 3'd3, 1, 2, 32'h108, 32'h100, 0);
    at_neg();
    chk("r37_rel_mis", 32'(mis), 1);
    drive(0, 3'd7, 0, 0, 32'h108, 32'h108, 0);
    at_neg();
    chk("r37_br", 32'(br_cnt), 7);
    chk("r37_entry", 32'(pred_f), 1);

    // non-branches: no taken, no update
    drive(1, 3'd7, 9, 9, 32'h114, 32'h114, 0);
    at_neg();
    chk("r38_op7", 32'(taken), 0);
    chk("r38_op7_mis", 32'(mis), 0);
    drive(1, 3'd6, 9, 9, 32'h114, 32'h114, 0);
    at_neg();
    chk("r38_op6", 32'(taken), 0);
    drive(0, 3'd1, 32'hFFFF_FFFD, 0, 32'h114, 32'h114, 0);
    at_neg();
    chk("r38_inv", 32'(taken), 0);
    chk("r38_inv_mis", 32'(mis), 0);
    drive(0, 3'd7, 0, 0, 32'h114, 32'h114, 0);
    at_neg();
    chk("r38_br", 32'(br_cnt), 7);
    chk("r38_entry", 32'(pred_f), 0);

    // continuous mispredicts saturate both counters
    drive(1, 3'd0, 1, 1, 32'h110, 32'h114, 0);
    repeat (65540) @(posedge clk);
    at_neg();
    chk("r39_miss_sat", 32'(miss_cnt), 32'hFFFF);
    chk("r39_br_sat", 32'(br_cnt), 32'hFFFF);
    chk("r39_mis", 32'(mis), 1);
    @(posedge clk);
    at_neg();
    chk("r39_miss_hold", 32'(miss_cnt), 32'hFFFF);

    // asynchronous reset mid-cycle
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("r39_rst_br", 32'(br_cnt), 0);
    chk("r39_rst_miss", 32'(miss_cnt), 0);
    chk("r39_rst_mis", 32'(mis), 1);
    for (int i = 0; i < 16; i++) begin
      pcf = 32'(i) << 2;
      #1;
      chk("r39_rst_entry", 32'(pred_f), 0);
    end
    @(posedge clk);
    #1;
    valid = 1; op = 3'd3; rs = 2; rt = 2;
    pcd = 32'h110; pcf = 32'h114; stall = 0;
    reset = 1'b1;
    at_neg();
    chk("r33_nt_mis", 32'(mis), 0);
    drive(0, 3'd7, 0, 0, 32'h110, 32'h110, 0);
    at_neg();
    chk("r33_entry", 32'(pred_f), 0);
    chk("r33_br", 32'(br_cnt), 1);
    chk("r33_miss", 32'(miss_cnt), 0);

    @(posedge clk);
    #1 chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter IDX_BITS, default 4, meaning log2 of branch-history-table (BHT) entries (16 entries).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the statistics counters.
REQ-003 SHALL have port clk  input  1  meaning single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port CMP_Op  input  3  meaning decoded D-stage compare op:
- 000 beq
- 001 bgtz
- 010 blez
- 011 bne
- 100 bgez/bgezal
- 101 bltz/bltzal
- 111 none
REQ-006 SHALL have port Valid_D  input  1  meaning D-stage holds a live instruction.
REQ-007 SHALL have port RS_D  input  32  meaning forwarded rs operand.
REQ-008 SHALL have port RT_D  input  32  meaning forwarded rt operand.
REQ-009 SHALL have port PC_D  input  32  meaning D-stage instruction address.
REQ-010 SHALL have port PC_F  input  32  meaning F-stage fetch address.
REQ-011 SHALL have port Stall  input  1  meaning F/D pipeline registers frozen this cycle.
REQ-012 SHALL have port Pred_F  output  1  meaning predicted-taken for PC_F.
REQ-013 SHALL have port Taken_D  output  1  meaning resolved branch outcome in D.
REQ-014 SHALL have port Mispredict_D  output  1  meaning F redirect/flush request.
REQ-015 SHALL have port Br_Count  output  CNT_W  meaning resolved-branch count.
REQ-016 SHALL have port Miss_Count  output  CNT_W  meaning misprediction count.

Function
REQ-017 SHALL compute Taken_D combinationally from CMP_Op, with RS_D/RT_D compares signed:
- 000: RS_D==RT_D
- 011: RS_D!=RT_D
- 001: RS_D>0
- 010: RS_D<=0
- 100: RS_D>=0
- 101: RS_D<0
- 110, 111: 0
REQ-018 SHALL define internal Branch_D = Valid_D & (CMP_Op not 110/111).
REQ-019 SHALL hold a BHT of 2^IDX_BITS 2-bit saturating counters (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T), indexed by PC[IDX_BITS+1:2].
REQ-020 SHALL drive Pred_F combinationally as bit 1 of BHT[PC_F index].
REQ-021 SHALL register Pred_F into internal Pred_D on each edge where Stall=0, and hold Pred_D while Stall=1.
REQ-022 SHALL load 0 into Pred_D instead of Pred_F on an edge where Mispredict_D=1, because the wrong-path fetch is squashed.
REQ-023 SHALL drive Mispredict_D = Branch_D & ~Stall & (Taken_D != Pred_D), combinationally, for the same cycle.
REQ-024 SHALL, on an edge with Branch_D=1 and Stall=0, update BHT[PC_D index]: increment toward 11 if Taken_D=1, decrement toward 00 if Taken_D=0.
REQ-025 SHALL saturate the BHT counters: 11 stays 11 when taken; 00 stays 00 when not taken.
REQ-026 SHALL apply exactly one BHT update per branch: a branch held in D by Stall=1 updates only on its first unstalled edge.
REQ-027 SHALL, when PC_F and PC_D indices collide in the update cycle, return the pre-update value on Pred_F (no write bypass), with the new value visible from the next cycle.
REQ-028 SHALL increment Br_Count on each update edge (REQ-024) and Miss_Count on each edge with Mispredict_D=1.
REQ-029 SHALL saturate Br_Count and Miss_Count at all-ones (no wrap).
REQ-030 SHALL keep Taken_D and Mispredict_D as pure functions of current inputs and Pred_D, with no extra latency.

Reset
REQ-031 SHALL, while reset=0, asynchronously force all BHT entries to 01, Pred_D=0, Br_Count=0 and Miss_Count=0.
REQ-032 SHALL show, during reset, Pred_F=0, plus Taken_D and Mispredict_D per their combinational equations with Pred_D=0.
REQ-033 SHALL abort any pending update on reset mid-operation, with the first update after reset release applied to the reset-valued table.

Verification
REQ-034 SHALL be covered by a bench scenario: after reset, CMP_Op=000, RS_D=RT_D=5, Valid_D=1, Stall=0 -> Taken_D=1, Mispredict_D=1, entry becomes 10, Br_Count=1, Miss_Count=1.
REQ-035 SHALL be covered by a bench scenario: same PC taken 3 more times -> entry saturates at 11, Pred_F=1 when PC_F matches, Mispredict_D=0 on the 3rd and later.
REQ-036 SHALL be covered by a bench scenario: CMP_Op=001 with RS_D=0x80000000 -> Taken_D=0; CMP_Op=101 with the same RS_D -> Taken_D=1 (signed compare).
REQ-037 SHALL be covered by a bench scenario: branch held in D with Stall=1 for 4 cycles, then released -> exactly one BHT update, Br_Count +1.
REQ-038 SHALL be covered by a bench scenario: CMP_Op=111 or Valid_D=0 with any operands -> Taken_D=0, no update, counters unchanged.
REQ-039 SHALL be covered by a bench scenario: Miss_Count preloaded to 0xFFFF via repeated mispredicts, one more mispredict -> stays 0xFFFF; then reset=0 mid-cycle -> all counters 0 and entries 01 immediately.
